// File: rtl/lfsr_pkg.sv
// lfsr_pkg: tap table, per-channel seed derivation and FSM encoding for the LFSR PRNG array
package lfsr_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_e;

  function automatic logic [31:0] taps(input int width);
    return width == 8  ? 32'h0000_00B8 :
           width == 16 ? 32'h0000_B400 :
           width == 24 ? 32'h00E1_0000 : 32'h8020_0003;
  endfunction

  function automatic logic [31:0] width_mask(input int width);
    return width >= 32 ? 32'hFFFF_FFFF : (32'd1 << width) - 32'd1;
  endfunction

  // Rotate left within the LFSR width by the channel index, fold in the index,
  // and never hand an LFSR the all-zero lock-up state.
  function automatic logic [31:0] derive_seed(input logic [31:0] seed, input int c, input int width);
    logic [31:0] m;
    logic [31:0] s;
    logic [31:0] r;
    int k;
    m = width_mask(width);
    s = seed & m;
    k = c % width;
    r = k == 0 ? s : (((s << k) | (s >> (width - k))) & m);
    r = (r ^ c) & m;
    return r == 32'd0 ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: one combinational Galois LFSR update (shift right, xor taps when the lsb falls out)
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o
);

  localparam logic [31:0] TAPS32 = taps(WIDTH);
  localparam logic [WIDTH-1:0] TAP = TAPS32[WIDTH-1:0];

  assign next_o = {1'b0, state_i[WIDTH-1:1]} ^ (state_i[0] ? TAP : '0);

endmodule

// File: rtl/lfsr_prng_array.sv
// lfsr_prng_array: CHANNELS parallel Galois LFSRs with warm-up, valid/ready output and channel-0 period detection
module lfsr_prng_array
  import lfsr_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          CHANNELS   = 3,
  parameter logic [31:0] RESET_SEED = 32'd1,
  parameter int          WARMUP     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      seed_load,
  input  logic [WIDTH-1:0]          seed_in,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      wrap,
  output logic [31:0]               period
);

  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
    $error("lfsr_prng_array: WIDTH must be 8, 16, 24 or 32");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("lfsr_prng_array: CHANNELS must be 1..16");
  end
  if (WARMUP < 0 || WARMUP > 255) begin : g_bad_warmup
    $error("lfsr_prng_array: WARMUP must be 0..255");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ch_q [CHANNELS];
  logic [WIDTH-1:0] ch_d [CHANNELS];
  logic [WIDTH-1:0] nxt  [CHANNELS];
  logic [WIDTH-1:0] seed0_q, seed0_d;
  logic [31:0]      cnt_q, cnt_d, cnt_inc;
  logic [31:0]      period_q, period_d;
  logic [7:0]       wu_q, wu_d;
  logic             wrap_q, wrap_d;
  logic             step;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    lfsr_step #(.WIDTH(WIDTH)) u_step (
      .state_i(ch_q[c]),
      .next_o (nxt[c])
    );
    assign out_data[c*WIDTH +: WIDTH] = ch_q[c];
  end

  assign out_valid = state_q == S_RUN;
  assign wrap      = wrap_q;
  assign period    = period_q;
  assign cnt_inc   = &cnt_q ? cnt_q : cnt_q + 32'd1;

  // Next-state: FSM sequencing, seed loading, stepping and wrap/period bookkeeping
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    seed0_d  = seed0_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wu_d     = wu_q;
    wrap_d   = 1'b0;
    step     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (seed_load) begin
          for (int c = 0; c < CHANNELS; c++) ch_d[c] = WIDTH'(derive_seed(32'(seed_in), c, WIDTH));
          seed0_d = WIDTH'(derive_seed(32'(seed_in), 0, WIDTH));
          cnt_d   = '0;
        end else if (en) begin
          state_d = WARMUP == 0 ? S_RUN : S_WARMUP;
          wu_d    = 8'(WARMUP);
        end
      end
      S_WARMUP: begin
        step    = 1'b1;
        wu_d    = wu_q - 8'd1;
        state_d = wu_q == 8'd1 ? S_RUN : S_WARMUP;
      end
      S_RUN: begin
        step    = out_ready;
        state_d = out_ready && !en ? S_IDLE : S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
    if (step) begin
      ch_d = nxt;
      if (nxt[0] == seed0_q) begin
        wrap_d   = 1'b1;
        period_d = cnt_inc;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // State registers; reset aborts any run and reloads the derived reset seed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      for (int c = 0; c < CHANNELS; c++) ch_q[c] <= WIDTH'(derive_seed(RESET_SEED, c, WIDTH));
      seed0_q  <= WIDTH'(derive_seed(RESET_SEED, 0, WIDTH));
      cnt_q    <= '0;
      period_q <= '0;
      wu_q     <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      seed0_q  <= seed0_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wu_q     <= wu_d;
      wrap_q   <= wrap_d;
    end
  end

endmodule

// File: tb/tb_lfsr_prng_array.sv
// tb_lfsr_prng_array: randomized self-checking bench for the LFSR PRNG array against a behavioural model
module tb_lfsr_prng_array;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        a_en, a_sl, a_rdy, a_valid, a_wrap;
  logic [7:0]  a_seed;
  logic [23:0] a_data;
  logic [31:0] a_period;

  logic        b_en, b_sl, b_rdy, b_valid, b_wrap;
  logic [7:0]  b_seed;
  logic [15:0] b_data;
  logic [31:0] b_period;

  logic        c_en, c_sl, c_rdy, c_valid, c_wrap;
  logic [31:0] c_seed;
  logic [95:0] c_data;
  logic [31:0] c_period;

  logic [31:0] m_a [3];
  logic [31:0] m_b [2];
  logic [31:0] m_c [3];
  int          m_steps;

  lfsr_prng_array #(.WIDTH(8), .CHANNELS(3), .RESET_SEED(32'd1), .WARMUP(0)) dut_a (
    .clk(clk), .reset(reset), .en(a_en), .seed_load(a_sl), .seed_in(a_seed), .out_ready(a_rdy),
    .out_valid(a_valid), .out_data(a_data), .wrap(a_wrap), .period(a_period));

  lfsr_prng_array #(.WIDTH(8), .CHANNELS(2), .RESET_SEED(32'd1), .WARMUP(4)) dut_b (
    .clk(clk), .reset(reset), .en(b_en), .seed_load(b_sl), .seed_in(b_seed), .out_ready(b_rdy),
    .out_valid(b_valid), .out_data(b_data), .wrap(b_wrap), .period(b_period));

  lfsr_prng_array #(.WIDTH(32), .CHANNELS(3), .RESET_SEED(32'd1), .WARMUP(0)) dut_c (
    .clk(clk), .reset(reset), .en(c_en), .seed_load(c_sl), .seed_in(c_seed), .out_ready(c_rdy),
    .out_valid(c_valid), .out_data(c_data), .wrap(c_wrap), .period(c_period));

  function automatic logic [31:0] m_step(input logic [31:0] s, input int w);
    logic [31:0] t;
    t = w == 8 ? 32'hB8 : w == 16 ? 32'hB400 : w == 24 ? 32'hE10000 : 32'h80200003;
    return s[0] ? (s >> 1) ^ t : s >> 1;
  endfunction

  function automatic logic [31:0] m_seed(input logic [31:0] seed, input int c, input int w);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (64'd1 << w) - 64'd1;
    r = ({32'd0, seed} & mask) << (c % w);
    r = (r | (r >> w)) & mask;
    r = r ^ 64'(c);
    return r == 64'd0 ? 32'd1 : r[31:0];
  endfunction

  function automatic logic [23:0] pack_a();
    logic [23:0] e;
    for (int c = 0; c < 3; c++) e[c*8 +: 8] = m_a[c][7:0];
    return e;
  endfunction

  task automatic adv_a();
    for (int c = 0; c < 3; c++) m_a[c] = m_step(m_a[c], 8);
    m_steps++;
  endtask

  task automatic test_reset();
    logic [23:0] e;
    reset = 1'b1;
    {a_en, a_sl, a_rdy, a_seed} = '0;
    {b_en, b_sl, b_rdy, b_seed} = '0;
    {c_en, c_sl, c_rdy, c_seed} = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) m_a[c] = m_seed(32'd1, c, 8);
    m_steps = 0;
    e = pack_a();
    tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", a_valid); end
    tests++; if (a_wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap: got %b expected 0", a_wrap); end
    tests++; if (a_period !== 32'd0) begin fails++; $display("FAIL reset_period: got %h expected 0", a_period); end
    tests++; if (a_data !== e) begin fails++; $display("FAIL reset_data: got %h expected %h", a_data, e); end
    tests++; if (a_data !== 24'h060301) begin fails++; $display("FAIL reset_data_lit: got %h expected 060301", a_data); end
    tests++; if (c_data[31:0] !== 32'h1) begin fails++; $display("FAIL reset_c_ch0: got %h expected 1", c_data[31:0]); end
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b expected 0", a_valid); end
  endtask

  task automatic test_sequence();
    logic [7:0] golden [6];
    logic [23:0] e;
    golden = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    a_en = 1'b1;
    a_rdy = 1'b1;
    @(posedge clk); #1;
    tests++; if (a_valid !== 1'b1) begin fails++; $display("FAIL seq_valid_rise: got %b expected 1", a_valid); end
    for (int i = 0; i < 6; i++) begin
      e = pack_a();
      tests++; if (a_data[7:0] !== golden[i]) begin fails++; $display("FAIL seq_ch0[%0d]: got %h expected %h", i, a_data[7:0], golden[i]); end
      tests++; if (a_data !== e) begin fails++; $display("FAIL seq_all[%0d]: got %h expected %h", i, a_data, e); end
      @(posedge clk); #1;
      adv_a();
    end
  endtask

  task automatic test_stall();
    logic [23:0] e;
    logic r;
    a_rdy = 1'b0;
    a_sl = 1'b1;
    a_seed = 8'($urandom);
    e = pack_a();
    repeat (5) begin
      @(posedge clk); #1;
      tests++; if (a_data !== e || a_valid !== 1'b1) begin fails++; $display("FAIL stall_hold: got %h/%b expected %h/1", a_data, a_valid, e); end
    end
    a_sl = 1'b0;
    a_rdy = 1'b1;
    @(posedge clk); #1;
    adv_a();
    e = pack_a();
    tests++; if (a_data !== e) begin fails++; $display("FAIL stall_resume: got %h expected %h", a_data, e); end
    for (int i = 0; i < 30; i++) begin
      r = 1'($urandom_range(0, 1));
      a_rdy = r;
      a_sl = 1'($urandom_range(0, 1));
      a_seed = 8'($urandom);
      @(posedge clk); #1;
      if (r) adv_a();
      e = pack_a();
      tests++; if (a_data !== e) begin fails++; $display("FAIL stall_rand[%0d]: got %h expected %h", i, a_data, e); end
    end
    a_sl = 1'b0;
  endtask

  task automatic test_wrap();
    logic [23:0] e;
    logic r, ew;
    int dut_wraps = 0;
    int guard = 0;
    while (m_steps < 520 && guard < 3000) begin
      guard++;
      r = $urandom_range(0, 3) != 0;
      a_rdy = r;
      @(posedge clk); #1;
      if (r) adv_a();
      ew = r && (m_steps % 255 == 0);
      e = pack_a();
      if (a_wrap === 1'b1) dut_wraps++;
      tests++; if (a_wrap !== ew) begin fails++; $display("FAIL wrap_pulse@%0d: got %b expected %b", m_steps, a_wrap, ew); end
      tests++; if (a_data !== e) begin fails++; $display("FAIL wrap_data@%0d: got %h expected %h", m_steps, a_data, e); end
      if (ew) begin
        tests++; if (a_data[7:0] !== 8'h01) begin fails++; $display("FAIL wrap_reseed: got %h expected 01", a_data[7:0]); end
        tests++; if (a_period !== 32'd255) begin fails++; $display("FAIL wrap_period: got %0d expected 255", a_period); end
      end
    end
    tests++; if (guard >= 3000) begin fails++; $display("FAIL wrap_budget: got %0d steps expected 520", m_steps); end
    tests++; if (dut_wraps !== 2) begin fails++; $display("FAIL wrap_count: got %0d expected 2", dut_wraps); end
  endtask

  task automatic test_en_drop();
    logic [23:0] e;
    a_rdy = 1'b0;
    a_en = 1'b0;
    e = pack_a();
    repeat (3) begin
      @(posedge clk); #1;
      tests++; if (a_valid !== 1'b1 || a_data !== e) begin fails++; $display("FAIL endrop_hold: got %b/%h expected 1/%h", a_valid, a_data, e); end
    end
    a_rdy = 1'b1;
    @(posedge clk); #1;
    adv_a();
    e = pack_a();
    tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL endrop_idle: got %b expected 0", a_valid); end
    tests++; if (a_data !== e) begin fails++; $display("FAIL endrop_last_step: got %h expected %h", a_data, e); end
    @(posedge clk); #1;
    tests++; if (a_valid !== 1'b0 || a_data !== e) begin fails++; $display("FAIL endrop_frozen: got %b/%h expected 0/%h", a_valid, a_data, e); end
  endtask

  task automatic test_seedload();
    logic [23:0] e;
    logic [7:0] s;
    a_sl = 1'b1;
    a_en = 1'b1;
    a_seed = 8'h00;
    @(posedge clk); #1;
    tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL load_beats_en: got %b expected 0", a_valid); end
    tests++; if (a_data !== 24'h020101) begin fails++; $display("FAIL load_zero: got %h expected 020101", a_data); end
    a_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = 8'($urandom);
      a_seed = s;
      @(posedge clk); #1;
      for (int c = 0; c < 3; c++) m_a[c] = m_seed(32'(s), c, 8);
      e = pack_a();
      tests++; if (a_data !== e) begin fails++; $display("FAIL load_rand[%0d] seed %h: got %h expected %h", i, s, a_data, e); end
    end
    m_steps = 0;
    a_sl = 1'b0;
    a_en = 1'b1;
    @(posedge clk); #1;
    tests++; if (a_valid !== 1'b1 || a_data !== pack_a()) begin fails++; $display("FAIL load_first: got %b/%h expected 1/%h", a_valid, a_data, pack_a()); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      adv_a();
      e = pack_a();
      tests++; if (a_data !== e) begin fails++; $display("FAIL load_run[%0d]: got %h expected %h", i, a_data, e); end
    end
  endtask

  task automatic test_warmup();
    logic [15:0] e;
    for (int c = 0; c < 2; c++) begin
      m_b[c] = m_seed(32'd1, c, 8);
      repeat (4) m_b[c] = m_step(m_b[c], 8);
    end
    e = {m_b[1][7:0], m_b[0][7:0]};
    b_en = 1'b1;
    b_rdy = 1'b1;
    @(posedge clk); #1;
    b_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (b_valid !== 1'b0) begin fails++; $display("FAIL warmup_low[%0d]: got %b expected 0", i, b_valid); end
      @(posedge clk); #1;
    end
    tests++; if (b_valid !== 1'b1) begin fails++; $display("FAIL warmup_rise: got %b expected 1", b_valid); end
    tests++; if (b_data[7:0] !== 8'h17) begin fails++; $display("FAIL warmup_ch0: got %h expected 17", b_data[7:0]); end
    tests++; if (b_data !== e) begin fails++; $display("FAIL warmup_all: got %h expected %h", b_data, e); end
    b_rdy = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      tests++; if (b_valid !== 1'b1 || b_data !== e) begin fails++; $display("FAIL warmup_hold: got %b/%h expected 1/%h", b_valid, b_data, e); end
    end
    b_rdy = 1'b1;
    @(posedge clk); #1;
    tests++; if (b_valid !== 1'b0) begin fails++; $display("FAIL warmup_drop: got %b expected 0", b_valid); end
  endtask

  task automatic test_async_reset();
    logic [95:0] e;
    logic r;
    for (int c = 0; c < 3; c++) m_c[c] = m_seed(32'd1, c, 32);
    c_en = 1'b1;
    c_rdy = 1'b1;
    @(posedge clk); #1;
    tests++; if (c_valid !== 1'b1) begin fails++; $display("FAIL c_valid_rise: got %b expected 1", c_valid); end
    for (int i = 0; i < 10; i++) begin
      e = {m_c[2], m_c[1], m_c[0]};
      tests++; if (c_data !== e) begin fails++; $display("FAIL c_run[%0d]: got %h expected %h", i, c_data, e); end
      r = 1'($urandom_range(0, 1));
      c_rdy = r;
      @(posedge clk); #1;
      if (r) for (int c = 0; c < 3; c++) m_c[c] = m_step(m_c[c], 32);
    end
    for (int c = 0; c < 3; c++) m_c[c] = m_seed(32'd1, c, 32);
    e = {m_c[2], m_c[1], m_c[0]};
    #2 reset = 1'b1;
    #1;
    tests++; if (c_valid !== 1'b0) begin fails++; $display("FAIL async_valid: got %b expected 0", c_valid); end
    tests++; if (c_data !== e) begin fails++; $display("FAIL async_data: got %h expected %h", c_data, e); end
    @(posedge clk); #1;
    reset = 1'b0;
    c_rdy = 1'b1;
    @(posedge clk); #1;
    tests++; if (c_valid !== 1'b1 || c_data[31:0] !== 32'h1) begin fails++; $display("FAIL restart: got %b/%h expected 1/00000001", c_valid, c_data[31:0]); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 3; c++) m_c[c] = m_step(m_c[c], 32);
      e = {m_c[2], m_c[1], m_c[0]};
      tests++; if (c_data !== e) begin fails++; $display("FAIL restart_run[%0d]: got %h expected %h", i, c_data, e); end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_wrap();
    test_en_drop();
    test_seedload();
    test_warmup();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish by 500000");
    $fatal(1, "timeout");
  end

endmodule
